// File: rtl/reser_luma_sad.sv
// rtl/reser_luma_sad.sv - per-mode luma residuals, block SAD accumulation and best-mode selection
module reser_luma_sad #(
    parameter int  PIX_W  = 8,
    parameter int  NPIX   = 16,
    parameter int  LANES  = 4,
    parameter int  NMODES = 9,
    localparam int SAD_W  = PIX_W + $clog2(NPIX),
    localparam int MODE_W = (NMODES > 1) ? $clog2(NMODES) : 1,
    localparam int RES_W  = PIX_W + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*PIX_W-1:0]          mb,
    input  logic [NMODES*LANES*PIX_W-1:0]   pred,
    input  logic [NMODES-1:0]               mode_mask,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [NMODES*LANES*RES_W-1:0]   res,
    output logic                            sad_valid,
    output logic [NMODES*SAD_W-1:0]         sad_all,
    output logic [MODE_W-1:0]               best_mode,
    output logic [SAD_W-1:0]                best_sad
);

    localparam int BEATS  = NPIX / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {ACCUM, SELECT, DONE} state_t;

    state_t                        state_q, state_d;
    logic [BEAT_W-1:0]             beat_q;
    logic                          res_valid_q;
    logic [NMODES*LANES*RES_W-1:0] res_q, res_d;
    logic [SAD_W-1:0]              acc_q [NMODES];
    logic [SAD_W-1:0]              beat_sum [NMODES];
    logic [RES_W-1:0]              diff [NMODES][LANES];
    logic [RES_W-1:0]              mag [NMODES][LANES];
    logic [NMODES-1:0]             mask_q;
    logic [MODE_W-1:0]             sel_q, run_mode_q, best_mode_q, cand_mode;
    logic [SAD_W-1:0]              run_sad_q, best_sad_q, cur_sad, cand_sad;
    logic [NMODES*SAD_W-1:0]       sad_all_q;
    logic                          cur_en, accept, beat_first, beat_last, sel_last;

    assign in_ready   = (state_q == ACCUM) && (!res_valid_q || res_ready);
    assign accept     = in_valid && in_ready && !flush;
    assign beat_first = (beat_q == '0);
    assign beat_last  = (beat_q == BEAT_W'(BEATS - 1));
    assign sel_last   = (sel_q == MODE_W'(NMODES - 1));

    assign res_valid  = res_valid_q;
    assign res        = res_q;
    assign sad_valid  = (state_q == DONE);
    assign sad_all    = sad_all_q;
    assign best_mode  = best_mode_q;
    assign best_sad   = best_sad_q;

    // Zero-extend both operands by one bit so the difference never wraps.
    always_comb begin
        res_d = '0;
        for (int m = 0; m < NMODES; m++) begin
            beat_sum[m] = '0;
            for (int l = 0; l < LANES; l++) begin
                diff[m][l] = {1'b0, mb[l*PIX_W +: PIX_W]} - {1'b0, pred[(m*LANES+l)*PIX_W +: PIX_W]};
                mag[m][l]  = diff[m][l][PIX_W] ? ('0 - diff[m][l]) : diff[m][l];
                beat_sum[m] = beat_sum[m] + SAD_W'(mag[m][l]);
                res_d[(m*LANES+l)*RES_W +: RES_W] = diff[m][l];
            end
        end
    end

    always_comb begin
        cur_sad = '0;
        cur_en  = 1'b0;
        for (int m = 0; m < NMODES; m++) begin
            if (sel_q == MODE_W'(m)) begin
                cur_sad = acc_q[m];
                cur_en  = mask_q[m];
            end
        end
        cand_mode = run_mode_q;
        cand_sad  = run_sad_q;
        // Strict less-than keeps the lowest index on ties.
        if (cur_en && (cur_sad < run_sad_q)) begin
            cand_mode = sel_q;
            cand_sad  = cur_sad;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (accept && beat_last) state_d = SELECT;
            SELECT:  if (sel_last) state_d = DONE;
            DONE:    state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
        if (flush) state_d = ACCUM;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_q      <= '0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
            mask_q      <= '0;
            sel_q       <= '0;
            run_mode_q  <= '0;
            run_sad_q   <= '0;
            best_mode_q <= '0;
            best_sad_q  <= '0;
            sad_all_q   <= '0;
            for (int m = 0; m < NMODES; m++) acc_q[m] <= '0;
        end else if (flush) begin
            beat_q      <= '0;
            res_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                res_q       <= res_d;
                res_valid_q <= 1'b1;
                beat_q      <= beat_last ? '0 : beat_q + BEAT_W'(1);
                if (beat_first) mask_q <= mode_mask;
                for (int m = 0; m < NMODES; m++)
                    acc_q[m] <= beat_first ? beat_sum[m] : acc_q[m] + beat_sum[m];
            end else if (res_ready) begin
                res_valid_q <= 1'b0;
            end
            // All-ones seed makes an empty mask fall out as mode 0 with max SAD.
            if (accept && beat_last) begin
                sel_q      <= '0;
                run_mode_q <= '0;
                run_sad_q  <= '1;
            end
            if (state_q == SELECT) begin
                sel_q      <= sel_q + MODE_W'(1);
                run_mode_q <= cand_mode;
                run_sad_q  <= cand_sad;
                if (sel_last) begin
                    best_mode_q <= cand_mode;
                    best_sad_q  <= cand_sad;
                    for (int m = 0; m < NMODES; m++) sad_all_q[m*SAD_W +: SAD_W] <= acc_q[m];
                end
            end
        end
    end

endmodule

// File: tb/tb_reser_luma_sad.sv
// tb/tb_reser_luma_sad.sv - self-checking bench for reser_luma_sad
module tb_reser_luma_sad;
    localparam int PIX_W = 8, NPIX = 16, LANES = 4, NMODES = 9;
    localparam int BEATS = NPIX / LANES, SAD_W = 12, MODE_W = 4, RW = PIX_W + 1;

    logic clk = 1'b0, reset = 1'b0, flush = 1'b0, in_valid = 1'b0, res_ready = 1'b1;
    logic in_ready, res_valid, sad_valid;
    logic [LANES*PIX_W-1:0]        mb = '0;
    logic [NMODES*LANES*PIX_W-1:0] pred = '0;
    logic [NMODES-1:0]             mode_mask = '0;
    logic [NMODES*LANES*RW-1:0]    res;
    logic [NMODES*SAD_W-1:0]       sad_all;
    logic [MODE_W-1:0]             best_mode;
    logic [SAD_W-1:0]              best_sad;

    reser_luma_sad #(.PIX_W(PIX_W), .NPIX(NPIX), .LANES(LANES), .NMODES(NMODES)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .mb(mb), .pred(pred), .mode_mask(mode_mask), .res_valid(res_valid), .res_ready(res_ready),
        .res(res), .sad_valid(sad_valid), .sad_all(sad_all), .best_mode(best_mode), .best_sad(best_sad)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int mbpix [NPIX];
    int predpix [NMODES][NPIX];
    logic [NMODES-1:0] blk_mask;
    int exp_sad [NMODES];
    int exp_mode, exp_best;

    typedef struct {
        int mb_v; int pred_base; int pred_step; logic [8:0] mask;
        int e_mode; int e_sad; int e_sad8;
    } row_t;
    row_t rows [6];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Reference: SAD is the plain sum of absolute pixel differences; best is
    // the first eligible mode reaching the minimum eligible SAD.
    task automatic model_block();
        int mn;
        mn = -1;
        for (int m = 0; m < NMODES; m++) begin
            exp_sad[m] = 0;
            for (int p = 0; p < NPIX; p++) begin
                int d;
                d = mbpix[p] - predpix[m][p];
                exp_sad[m] += (d < 0) ? -d : d;
            end
            if (blk_mask[m] && (mn < 0 || exp_sad[m] < mn)) mn = exp_sad[m];
        end
        exp_mode = 0;
        exp_best = (1 << SAD_W) - 1;
        if (mn >= 0) begin
            exp_best = mn;
            for (int m = NMODES - 1; m >= 0; m--)
                if (blk_mask[m] && exp_sad[m] == mn) exp_mode = m;
        end
    endtask

    function automatic logic [NMODES*LANES*RW-1:0] exp_res(input int b);
        logic [NMODES*LANES*RW-1:0] r;
        r = '0;
        for (int m = 0; m < NMODES; m++)
            for (int l = 0; l < LANES; l++)
                r[(m*LANES+l)*RW +: RW] = RW'(mbpix[b*LANES+l] - predpix[m][b*LANES+l]);
        return r;
    endfunction

    function automatic logic [NMODES*SAD_W-1:0] exp_sad_all();
        logic [NMODES*SAD_W-1:0] v;
        for (int m = 0; m < NMODES; m++) v[m*SAD_W +: SAD_W] = SAD_W'(exp_sad[m]);
        return v;
    endfunction

    task automatic drive_beat(input int b);
        for (int l = 0; l < LANES; l++) mb[l*PIX_W +: PIX_W] = PIX_W'(mbpix[b*LANES+l]);
        for (int m = 0; m < NMODES; m++)
            for (int l = 0; l < LANES; l++)
                pred[(m*LANES+l)*PIX_W +: PIX_W] = PIX_W'(predpix[m][b*LANES+l]);
        mode_mask = blk_mask;
    endtask

    task automatic send_beat(input int b);
        int waitc;
        bit ok;
        waitc = 0;
        ok = 0;
        @(negedge clk);
        drive_beat(b);
        in_valid = 1'b1;
        while (!ok && waitc < 50) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                ok = 1;
            end else begin
                @(negedge clk);
                waitc++;
            end
        end
        if (!ok) fail_now("beat_handshake");
    endtask

    task automatic wait_result();
        int cnt;
        bit got;
        cnt = 1;
        got = 0;
        while (!got && cnt < 40) begin
            @(negedge clk);
            #1;
            cnt++;
            if (sad_valid) got = 1;
            else if (cnt < 10) chk("in_ready_busy", in_ready, 0);
        end
        if (!got) fail_now("sad_valid");
        else begin
            chk("sad_latency", cnt, 10);
            chk("sad_all", sad_all, exp_sad_all());
            chk("best_mode", best_mode, exp_mode);
            chk("best_sad", best_sad, exp_best);
            @(negedge clk);
            #1;
            chk("sad_valid_pulse", sad_valid, 0);
        end
    endtask

    task automatic run_block(input int stall_beat, input int stall_len);
        model_block();
        for (int b = 0; b < BEATS; b++) begin
            send_beat(b);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk("res_valid", res_valid, 1);
            chk("res_beat", res, exp_res(b));
            if (b == stall_beat) begin
                res_ready = 1'b0;
                if (b + 1 < BEATS) begin
                    drive_beat(b + 1);
                    in_valid = 1'b1;
                end
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    #1;
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_res_valid", res_valid, 1);
                    chk("stall_res_hold", res, exp_res(b));
                end
                in_valid  = 1'b0;
                res_ready = 1'b1;
            end
        end
        wait_result();
    endtask

    task automatic fill_uniform(input int mb_v, input int base, input int step);
        for (int p = 0; p < NPIX; p++) begin
            mbpix[p] = mb_v;
            for (int m = 0; m < NMODES; m++) predpix[m][p] = base + step * m;
        end
    endtask

    task automatic fill_random();
        for (int p = 0; p < NPIX; p++) begin
            mbpix[p] = $urandom_range(0, 255);
            for (int m = 0; m < NMODES; m++) predpix[m][p] = $urandom_range(0, 255);
        end
    endtask

    initial begin
        int saved_mode, saved_best;
        bit seen;
        rows[0] = '{200, 200, -1, 9'h1FF, 0, 0,    128};
        rows[1] = '{0,   255,  0, 9'h1FF, 0, 4080, 4080};
        rows[2] = '{0,   255,  0, 9'h000, 0, 4095, 4080};
        rows[3] = '{100, 90,   1, 9'h1FF, 8, 32,   32};
        rows[4] = '{100, 90,   1, 9'h0FF, 7, 48,   32};
        rows[5] = '{255, 0,    0, 9'h1FF, 0, 4080, 4080};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_sad_valid", sad_valid, 0);
        chk("rst_res", res, 0);
        chk("rst_sad_all", sad_all, 0);
        chk("rst_best_mode", best_mode, 0);
        chk("rst_best_sad", best_sad, 0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 6; i++) begin
            fill_uniform(rows[i].mb_v, rows[i].pred_base, rows[i].pred_step);
            blk_mask = rows[i].mask;
            run_block(-1, 0);
            chk("row_best_mode", best_mode, rows[i].e_mode);
            chk("row_best_sad", best_sad, rows[i].e_sad);
            chk("row_sad8", sad_all[8*SAD_W +: SAD_W], rows[i].e_sad8);
        end

        for (int p = 0; p < NPIX; p++) begin
            mbpix[p] = 50;
            for (int m = 0; m < NMODES; m++) predpix[m][p] = (m == 3 || m == 5) ? 50 : 0;
        end
        predpix[3][0] = 30;
        predpix[5][5] = 70;
        blk_mask = 9'h1FF;
        run_block(-1, 0);
        chk("tie_low_index", best_mode, 3);
        chk("tie_sad", best_sad, 20);
        blk_mask = 9'h1F7;
        run_block(-1, 0);
        chk("tie_masked", best_mode, 5);
        blk_mask = 9'h000;
        run_block(-1, 0);
        chk("empty_mode", best_mode, 0);
        chk("empty_sad", best_sad, 12'hFFF);

        fill_uniform(200, 200, -1);
        blk_mask = 9'h1FF;
        run_block(1, 3);
        chk("stall_sad3", sad_all[3*SAD_W +: SAD_W], 48);

        saved_mode = exp_mode;
        saved_best = exp_best;
        fill_random();
        blk_mask = 9'h1FF;
        send_beat(0);
        @(negedge clk);
        in_valid = 1'b0;
        send_beat(1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        drive_beat(2);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_res_valid", res_valid, 0);
        chk("flush_sad_valid", sad_valid, 0);
        chk("flush_keep_mode", best_mode, saved_mode);
        chk("flush_keep_sad", best_sad, saved_best);
        fill_random();
        blk_mask = 9'h1FF;
        run_block(-1, 0);

        for (int i = 0; i < 8; i++) begin
            int sb;
            fill_random();
            blk_mask = (i == 3) ? 9'h000 : 9'($urandom_range(1, 511));
            sb = $urandom_range(0, 3);
            run_block((sb == 3) ? -1 : sb, $urandom_range(1, 4));
        end

        fill_random();
        blk_mask = 9'h1FF;
        for (int b = 0; b < BEATS; b++) begin
            send_beat(b);
            @(negedge clk);
            in_valid = 1'b0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rsel_res_valid", res_valid, 0);
        chk("rsel_sad_valid", sad_valid, 0);
        chk("rsel_res", res, 0);
        chk("rsel_sad_all", sad_all, 0);
        chk("rsel_best_mode", best_mode, 0);
        chk("rsel_best_sad", best_sad, 0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (sad_valid) seen = 1;
        end
        chk("rsel_no_pulse", seen, 0);
        fill_random();
        blk_mask = 9'h0F0;
        run_block(-1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
